// File: rtl/jkff_scan_ctrl.sv
// jkff_scan_ctrl
// Scan load/unload controller for a jkff_generic register bank. One START
// shifts an N-bit pattern into the bank through TEST/SCANIN and captures
// the bank's previous contents from SCANOUT. With RESTORE=1 the tail bit is
// fed straight back into the chain, so the bank is read without being
// altered.
module jkff_scan_ctrl #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         START,
  input  logic         RESTORE,
  input  logic [N-1:0] DIN,
  input  logic         SCANOUT,
  output logic         READY,
  output logic         TEST,
  output logic         SCANIN,
  output logic [N-1:0] DOUT,
  output logic         DVALID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter is loaded with N-1 so that SHIFT lasts exactly N cycles.
  localparam logic [6:0] CNT_INIT = 7'(N - 1);

  state_t       state_reg, state_next;
  logic [N-1:0] sh_reg, sh_next;
  logic [N-1:0] cap_reg, cap_next;
  logic [N-1:0] dout_reg, dout_next;
  logic [6:0]   cnt_reg, cnt_next;
  logic         rst_mode_reg, rst_mode_next;
  logic         test_reg, test_next;
  logic         dvalid_reg, dvalid_next;

  // One-step left shifts of the pattern and capture registers. Built per
  // bit so that N=1 collapses to a direct load without out-of-range slices.
  logic [N-1:0] sh_shift;
  logic [N-1:0] cap_shift;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign sh_shift[gi]  = 1'b0;
        assign cap_shift[gi] = SCANOUT;
      end else begin : g_upper
        assign sh_shift[gi]  = sh_reg[gi-1];
        assign cap_shift[gi] = cap_reg[gi-1];
      end
    end
  endgenerate

  // Next-state and next-output logic for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    cap_next      = cap_reg;
    dout_next     = dout_reg;
    cnt_next      = cnt_reg;
    rst_mode_next = rst_mode_reg;
    test_next     = 1'b0;
    dvalid_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (START) begin
          sh_next       = DIN;
          rst_mode_next = RESTORE;
          cnt_next      = CNT_INIT;
          test_next     = 1'b1;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        // SCANOUT is the bank tail before this edge's shift.
        cap_next = cap_shift;
        sh_next  = sh_shift;
        cnt_next = cnt_reg - 7'd1;
        if (cnt_reg == 7'd0) begin
          // TEST drops on the edge that enters DONE, so the bank never
          // sees a functional update in the middle of an operation.
          state_next = DONE;
        end else begin
          test_next = 1'b1;
        end
      end
      DONE: begin
        dout_next   = cap_reg;
        dvalid_next = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_reg    <= IDLE;
      sh_reg       <= '0;
      cap_reg      <= '0;
      dout_reg     <= '0;
      cnt_reg      <= '0;
      rst_mode_reg <= 1'b0;
      test_reg     <= 1'b0;
      dvalid_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      cap_reg      <= cap_next;
      dout_reg     <= dout_next;
      cnt_reg      <= cnt_next;
      rst_mode_reg <= rst_mode_next;
      test_reg     <= test_next;
      dvalid_reg   <= dvalid_next;
    end
  end

  // Recirculating the tail keeps the bank contents intact after N shifts.
  assign SCANIN = (state_reg == SHIFT) ? (rst_mode_reg ? SCANOUT : sh_reg[N-1]) : 1'b0;
  assign READY  = (state_reg == IDLE);
  assign TEST   = test_reg;
  assign DOUT   = dout_reg;
  assign DVALID = dvalid_reg;

endmodule

// File: tb/tb_jkff_scan_ctrl.sv
// Testbench for jkff_scan_ctrl: an N=8 and an N=1 controller, each driving a
// behavioural register bank. The expected results of each operation come
// from the bank contents before the operation and the requested pattern.
module tb_jkff_scan_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         start, restore;
  logic [N-1:0] din;
  logic         scanout;
  logic         ready, test, scanin, dvalid;
  logic [N-1:0] dout;

  logic start1, restore1, din1, scanout1;
  logic ready1, test1, scanin1, dvalid1, dout1;

  logic [N-1:0] bank8;
  logic         bank1;
  logic         pre8_en = 1'b0, pre1_en = 1'b0;
  logic [N-1:0] pre8_val = '0;
  logic         pre1_val = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  jkff_scan_ctrl #(.N(N)) dut (
    .CLK(clk), .CLR(clr), .START(start), .RESTORE(restore), .DIN(din),
    .SCANOUT(scanout), .READY(ready), .TEST(test), .SCANIN(scanin),
    .DOUT(dout), .DVALID(dvalid)
  );

  jkff_scan_ctrl #(.N(1)) dut1 (
    .CLK(clk), .CLR(clr), .START(start1), .RESTORE(restore1), .DIN(din1),
    .SCANOUT(scanout1), .READY(ready1), .TEST(test1), .SCANIN(scanin1),
    .DOUT(dout1), .DVALID(dvalid1)
  );

  // Behavioural banks: shift left, fill bit 0 from SCANIN while TEST is high.
  always @(posedge clk) begin
    if (pre8_en)   bank8 <= pre8_val;
    else if (test) bank8 <= {bank8[N-2:0], scanin};
    if (pre1_en)    bank1 <= pre1_val;
    else if (test1) bank1 <= scanin1;
  end

  assign scanout  = bank8[N-1];
  assign scanout1 = bank1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preset8(input logic [N-1:0] v);
    pre8_val = v;
    pre8_en  = 1'b1;
    @(negedge clk);
    pre8_en  = 1'b0;
  endtask

  task automatic preset1(input logic v);
    pre1_val = v;
    pre1_en  = 1'b1;
    @(negedge clk);
    pre1_en  = 1'b0;
  endtask

  // One N=8 operation, called at a negedge with the controller idle.
  // busy: extra START pulses (DIN=0) sampled at edges 3 and N+1.
  // hold: START stays high throughout; returns at the DVALID sample.
  task automatic run_op(input logic [N-1:0] d, input logic r, input bit busy, input bit hold);
    logic [N-1:0] old_bank, exp_bank, sin_seq;
    int tcnt, rdy_low, dv_early, start_cyc;
    old_bank  = bank8;
    exp_bank  = r ? old_bank : d;
    sin_seq   = '0;
    tcnt      = 0;
    rdy_low   = 0;
    dv_early  = 0;
    start_cyc = cyc;
    start     = 1'b1;
    din       = d;
    restore   = r;
    for (int k = 0; k <= N + 1; k++) begin
      @(negedge clk);
      if (k <= N) begin
        if (test)    tcnt++;
        if (!ready)  rdy_low++;
        if (dvalid)  dv_early++;
        if (k < N)   sin_seq = {sin_seq[N-2:0], scanin};
      end else begin
        check("ready_back", 32'(ready), 32'd1);
        check("dvalid", 32'(dvalid), 32'd1);
        check("dout", 32'(dout), 32'(old_bank));
      end
      if (!hold) begin
        start = busy && (k == 2 || k == N);
        if (busy && k == 2) begin
          din     = '0;
          restore = 1'b0;
        end
      end
    end
    check("test_cycles", 32'(tcnt), 32'(N));
    check("busy_ready", 32'(rdy_low), 32'(N + 1));
    check("early_dvalid", 32'(dv_early), 32'd0);
    check("scanin_seq", 32'(sin_seq), 32'(exp_bank));
    check("bank", 32'(bank8), 32'(exp_bank));
    $display("op din=%02h restore=%0d busy=%0d hold=%0d old=%02h dout=%02h bank=%02h start_cyc=%0d",
             d, r, busy, hold, old_bank, dout, bank8, start_cyc);
  endtask

  // One N=1 operation, called at a negedge with the controller idle.
  task automatic run_op1(input logic d, input logic r);
    logic old_bank, exp_bank;
    old_bank = bank1;
    exp_bank = r ? old_bank : d;
    start1   = 1'b1;
    din1     = d;
    restore1 = r;
    @(negedge clk);
    start1 = 1'b0;
    check("n1_test_hi", 32'(test1), 32'd1);
    check("n1_scanin", 32'(scanin1), 32'(exp_bank));
    @(negedge clk);
    check("n1_test_lo", 32'(test1), 32'd0);
    check("n1_no_dvalid", 32'(dvalid1), 32'd0);
    @(negedge clk);
    check("n1_dvalid", 32'(dvalid1), 32'd1);
    check("n1_dout", 32'(dout1), 32'(old_bank));
    check("n1_bank", 32'(bank1), 32'(exp_bank));
    check("n1_ready", 32'(ready1), 32'd1);
    $display("op1 din=%0d restore=%0d old=%0d dout=%0d bank=%0d", d, r, old_bank, dout1, bank1);
  endtask

  initial begin
    int dv;
    logic [N-1:0] c0;
    clr = 1'b0; start = 1'b0; restore = 1'b0; din = '0;
    start1 = 1'b0; restore1 = 1'b0; din1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_test", 32'(test), 32'd0);
    check("rst_scanin", 32'(scanin), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_n1_dout", 32'(dout1), 32'd0);
    clr = 1'b1;

    // Load
    preset8(8'hA5);
    run_op(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("dout_hold", 32'(dout), 32'hA5);
    check("dvalid_once", 32'(dvalid), 32'd0);

    // Non-destructive read
    preset8(8'hA5);
    run_op(8'hFF, 1'b1, 1'b0, 1'b0);

    // Busy rejection
    run_op(8'h3C, 1'b0, 1'b1, 1'b0);
    dv = 0;
    repeat (12) begin
      @(negedge clk);
      if (dvalid || test) dv++;
    end
    check("busy_no_extra_op", 32'(dv), 32'd0);

    // Back-to-back with START held
    c0 = 8'h00;
    run_op(8'h01, 1'b0, 1'b0, 1'b1);
    dv = cyc;
    run_op(8'h02, 1'b0, 1'b0, 1'b1);
    check("b2b_period", 32'(cyc - dv), 32'(N + 2));
    start = 1'b0;
    @(negedge clk);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) preset8(8'($urandom));
      run_op(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0);
    end

    // Reset in the middle of SHIFT, asserted for the 4th shift edge
    preset8(8'h96);
    start = 1'b1; din = 8'h0F; restore = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("abort_test", 32'(test), 32'd0);
    check("abort_scanin", 32'(scanin), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_dout", 32'(dout), 32'd0);
    clr = 1'b1;
    dv = 0;
    repeat (12) begin
      @(negedge clk);
      if (dvalid) dv++;
    end
    check("abort_no_dvalid", 32'(dv), 32'd0);
    run_op(8'h5A, 1'b0, 1'b0, 1'b0);

    // N=1 build
    preset1(1'b1);
    run_op1(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) preset1(1'($urandom));
      run_op1(1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
